// File: rtl/pwm_phase_sequencer_pkg.sv
// Shared types and constants for the PWM phase sequencer.
package pwm_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DWELL = 2'd2
    } seq_state_e;

    localparam int                 THETA_W   = 8;
    localparam logic [THETA_W-1:0] THETA_MAX = 8'd255;

endpackage

// File: rtl/pwm_step_prescaler.sv
// Clock prescaler: produces a tick every div clocks while enabled (div of 0 acts as 1).
module pwm_step_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    assign tick    = enable && (cnt == div_eff - DIV_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/pwm_phase_sequencer.sv
// Phase sequencer: steps an 8-bit theta through bursts of sine periods separated by dwells.
// repeat_en carries the loop request (the bare word repeat is reserved in SystemVerilog).
//
// state | meaning
// IDLE  | waiting for start; theta parked at 0
// RUN   | theta advancing once every div_l clocks
// DWELL | theta held at 0 for dwell_l clocks between bursts
module pwm_phase_sequencer
    import pwm_phase_sequencer_pkg::*;
#(
    parameter int DIV_W   = 24,
    parameter int CYC_W   = 8,
    parameter int DWELL_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [DIV_W-1:0]   div,
    input  logic [CYC_W-1:0]   n_cycles,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               repeat_en,
    output logic [THETA_W-1:0] theta,
    output logic               step,
    output logic               wrap,
    output logic               busy,
    output logic               in_dwell,
    output logic               done
);

    seq_state_e         state, state_nxt;
    logic [DIV_W-1:0]   div_l;
    logic [CYC_W-1:0]   n_cycles_l, per_cnt;
    logic [DWELL_W-1:0] dwell_l, dwell_cnt;
    logic               repeat_l;
    logic               tick, accept, abort, adv, burst_end;
    logic               run_clr, dwell_load, done_nxt;

    assign accept    = (state == IDLE) && start && !stop;
    assign abort     = (state != IDLE) && stop;
    assign adv       = tick && !stop;
    assign burst_end = adv && (theta == THETA_MAX) && (n_cycles_l != '0)
                       && (per_cnt == n_cycles_l - CYC_W'(1));

    pwm_step_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (state == RUN),
        .clear  (run_clr),
        .div    (div_l),
        .tick   (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        run_clr    = 1'b0;
        dwell_load = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                    run_clr   = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (burst_end) begin
                    if (dwell_l != '0) begin
                        state_nxt  = DWELL;
                        dwell_load = 1'b1;
                    end else if (repeat_l) begin
                        run_clr = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (dwell_cnt == '0) begin
                    if (repeat_l) begin
                        state_nxt = RUN;
                        run_clr   = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta      <= '0;
            step       <= 1'b0;
            wrap       <= 1'b0;
            busy       <= 1'b0;
            in_dwell   <= 1'b0;
            done       <= 1'b0;
            div_l      <= '0;
            n_cycles_l <= '0;
            dwell_l    <= '0;
            repeat_l   <= 1'b0;
            per_cnt    <= '0;
            dwell_cnt  <= '0;
        end else begin
            step     <= 1'b0;
            wrap     <= 1'b0;
            done     <= done_nxt;
            busy     <= (state_nxt != IDLE);
            in_dwell <= (state_nxt == DWELL);
            if (accept) begin
                div_l      <= (div == '0) ? DIV_W'(1) : div;
                n_cycles_l <= n_cycles;
                dwell_l    <= dwell;
                repeat_l   <= repeat_en;
            end
            if (abort) begin
                theta <= '0;
            end else if (adv) begin
                theta <= theta + THETA_W'(1);
                step  <= 1'b1;
                wrap  <= (theta == THETA_MAX);
                if ((theta == THETA_MAX) && (n_cycles_l != '0))
                    per_cnt <= per_cnt + CYC_W'(1);
            end
            // A new burst starts from theta 0 with no periods counted; this overrides the advance.
            if (run_clr) begin
                theta   <= '0;
                per_cnt <= '0;
            end
            if (dwell_load)
                dwell_cnt <= dwell_l - DWELL_W'(1);
            else if ((state == DWELL) && (dwell_cnt != '0))
                dwell_cnt <= dwell_cnt - DWELL_W'(1);
        end
    end

endmodule

// File: tb/tb_pwm_phase_sequencer.sv
// Self-checking bench for pwm_phase_sequencer against a time-based behavioural model.
module tb_pwm_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [23:0] div = '0;
    logic [7:0]  n_cycles = '0;
    logic [31:0] dwell = '0;
    logic        repeat_en = 1'b0;
    logic [7:0]  theta;
    logic        step, wrap, busy, in_dwell, done;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 run, 2 dwell; m_t counts clocks since entering the mode.
    int         m_mode = 0, m_t = 0, m_n = 1, m_ncyc = 0, m_dw = 0;
    bit         m_rep = 0;
    logic [7:0] e_theta = '0;
    bit         e_step = 0, e_wrap = 0, e_busy = 0, e_dwell = 0, e_done = 0;

    pwm_phase_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .div       (div),
        .n_cycles  (n_cycles),
        .dwell     (dwell),
        .repeat_en (repeat_en),
        .theta     (theta),
        .step      (step),
        .wrap      (wrap),
        .busy      (busy),
        .in_dwell  (in_dwell),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_vec();
        return {theta, step, wrap, busy, in_dwell, done};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {e_theta, e_step, e_wrap, e_busy, e_dwell, e_done};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_n = 1; m_ncyc = 0; m_dw = 0; m_rep = 0;
        e_theta = '0; e_step = 0; e_wrap = 0; e_busy = 0; e_dwell = 0; e_done = 0;
    endtask

    // Predict the outputs after the coming clock edge from the inputs currently driven.
    task automatic model_edge();
        int k;
        e_step = 0; e_wrap = 0; e_done = 0;
        case (m_mode)
            0: if (start && !stop) begin
                m_n = (div == 0) ? 1 : int'(div);
                m_ncyc = int'(n_cycles); m_dw = int'(dwell); m_rep = repeat_en;
                m_mode = 1; m_t = 0; e_theta = '0;
            end
            1: if (stop) begin
                m_mode = 0; e_theta = '0; e_done = 1;
            end else begin
                m_t++;
                if (m_t % m_n == 0) begin
                    k = m_t / m_n;
                    e_step = 1;
                    e_theta = 8'(k % 256);
                    e_wrap = (k % 256 == 0);
                    if (m_ncyc != 0 && k == 256 * m_ncyc) begin
                        m_t = 0;
                        if (m_dw != 0) m_mode = 2;
                        else if (!m_rep) begin m_mode = 0; e_done = 1; end
                    end
                end
            end
            default: if (stop) begin
                m_mode = 0; e_theta = '0; e_done = 1;
            end else begin
                m_t++;
                if (m_t == m_dw) begin
                    m_t = 0;
                    if (m_rep) m_mode = 1;
                    else begin m_mode = 0; e_done = 1; end
                end
            end
        endcase
        e_busy = (m_mode != 0);
        e_dwell = (m_mode == 2);
    endtask

    task automatic tick_cycle(input logic st, input logic sp);
        start = st; stop = sp;
        model_edge();
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic set_cfg(input int d, input int n, input int dw, input bit r);
        div = 24'(d); n_cycles = 8'(n); dwell = 32'(dw); repeat_en = r;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== 13'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), 13'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_single_burst();
        int n_steps = 0, n_wraps = 0, done_at = -1;
        set_cfg(3, 1, 0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 800; i++) begin
            tick_cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_burst cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (step) n_steps++;
            if (wrap) n_wraps++;
            if (done) done_at = i;
        end
        checks++;
        if (n_steps != 256) begin errors++; $display("FAIL burst_steps: got %0d want 256", n_steps); end
        checks++;
        if (n_wraps != 1) begin errors++; $display("FAIL burst_wraps: got %0d want 1", n_wraps); end
        checks++;
        if (done_at != 768) begin errors++; $display("FAIL burst_done_time: got %0d want 768", done_at); end
    endtask

    task automatic test_dwell_repeat();
        int first_dwell = -1, dwell_cycles = 0, rerun_step = -1;
        set_cfg(0, 2, 10, 1'b1);
        tick_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 1100; i++) begin
            tick_cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL dwell_repeat cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (i <= 600 && in_dwell) begin
                dwell_cycles++;
                if (first_dwell < 0) first_dwell = i;
            end
            if (i > 512 && i <= 600 && step && rerun_step < 0) rerun_step = i;
        end
        checks++;
        if (first_dwell != 512) begin errors++; $display("FAIL dwell_entry: got %0d want 512", first_dwell); end
        checks++;
        if (dwell_cycles != 10) begin errors++; $display("FAIL dwell_length: got %0d want 10", dwell_cycles); end
        checks++;
        if (rerun_step != 523) begin errors++; $display("FAIL rerun_first_step: got %0d want 523", rerun_step); end
        tick_cycle(1'b0, 1'b1);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL dwell_repeat_stop: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stop_on_step();
        int r;
        r = int'($urandom_range(5, 300));
        set_cfg(2, 0, 0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        for (int i = 0; i < 2 * r + 1; i++) begin
            tick_cycle(1'b0, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stop_lead cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        tick_cycle(1'b0, 1'b1);
        checks++;
        if ({theta, step, busy, done} !== {8'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL stop_on_step: got theta=%0d step=%b busy=%b done=%b want 0/0/0/1",
                     theta, step, busy, done);
        end
        tick_cycle(1'b0, 1'b0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL stop_after: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_start_stop_idle();
        set_cfg(1, 1, 0, 1'b0);
        tick_cycle(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({busy, done} !== 2'b00 || dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_stop_idle cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            tick_cycle(1'b0, 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        int last_step = -1, bad_gap = 0;
        set_cfg(4, 1, 0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            if (i == 50 || i == 151) set_cfg(1, 3, 7, 1'b1);
            tick_cycle(i == 50 || i == 151, 1'b0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL start_ignored cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
            if (step) begin
                if (i - last_step != 4 && last_step > 0) bad_gap++;
                last_step = i;
            end
        end
        checks++;
        if (bad_gap != 0) begin errors++; $display("FAIL step_spacing: got %0d bad gaps want 0", bad_gap); end
        tick_cycle(1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        set_cfg(1, 1, 0, 1'b1);
        tick_cycle(1'b1, 1'b0);
        for (int i = 1; i <= 600; i++) begin
            tick_cycle(1'b0, i == 600);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_cfg(2, 0, 0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        for (int i = 0; i < 37; i++) tick_cycle(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== 13'h0) begin
            errors++;
            $display("FAIL reset_mid_run: got %h want %h", dut_vec(), 13'h0);
        end
        @(posedge clk); #1;
        checks++;
        if (dut_vec() !== 13'h0) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", dut_vec(), 13'h0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick_cycle(1'b0, 1'b0);
        set_cfg(1, 0, 0, 1'b0);
        tick_cycle(1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick_cycle(1'b0, i == 299);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL restart cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            tick_cycle($urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_dwell_repeat();
        test_stop_on_step();
        test_start_stop_idle();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
